// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RV64 MEM stage: data-cache load/store and write-back handoff
module memory_access_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_data,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic              flush,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic [XLEN-1:0]   dc_req_addr,
    output logic              dc_req_we,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [7:0]        dc_req_be,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   loaded_data,
    output logic [XLEN-1:0]   alu_data,
    output logic [CTRL_W-1:0] control_signals,
    output logic              misaligned
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DRAIN} state_t;

    state_t              r_state;
    logic                r_ex_ready;
    logic                r_dc_req_valid;
    logic                r_wb_valid;
    logic [XLEN-1:0]     r_dc_req_addr;
    logic                r_dc_req_we;
    logic [XLEN-1:0]     r_dc_req_wdata;
    logic [7:0]          r_dc_req_be;
    logic [XLEN-1:0]     r_loaded;
    logic [XLEN-1:0]     r_alu;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                r_mis;
    logic [2:0]          r_off;
    logic [2:0]          r_f3;
    logic                r_is_load;

    logic [2:0]          w_off;
    logic [2:0]          w_f3;
    logic                w_mem;
    logic                w_store;
    logic [7:0]          w_be_base;
    logic [2:0]          w_size_mask;
    logic                w_mis;
    logic [CTRL_W-1:0]   w_ctrl_cap;
    logic [XLEN-1:0]     w_shifted;
    logic [XLEN-1:0]     w_load_ext;

    assign w_off   = ex_alu_data[2:0];
    assign w_f3    = ex_ctrl[10:8];
    assign w_mem   = ex_ctrl[6] | ex_ctrl[7];
    assign w_store = ex_ctrl[7];

    always_comb begin
        w_be_base   = 8'h01;
        w_size_mask = 3'd0;
        case (w_f3[1:0])
            2'd0: begin w_be_base = 8'h01; w_size_mask = 3'd0; end
            2'd1: begin w_be_base = 8'h03; w_size_mask = 3'd1; end
            2'd2: begin w_be_base = 8'h0F; w_size_mask = 3'd3; end
            default: begin w_be_base = 8'hFF; w_size_mask = 3'd7; end
        endcase
    end

    assign w_mis = w_mem && ((w_off & w_size_mask) != 3'd0);

    // Stores and faulting accesses never write a destination register.
    always_comb begin
        w_ctrl_cap    = ex_ctrl;
        w_ctrl_cap[5] = ex_ctrl[5] & ~(w_mis | w_store);
    end

    assign w_shifted = dc_resp_data >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = '0;
        case (r_f3[1:0])
            2'd0: w_load_ext = {{(XLEN-8){w_shifted[7] & ~r_f3[2]}}, w_shifted[7:0]};
            2'd1: w_load_ext = {{(XLEN-16){w_shifted[15] & ~r_f3[2]}}, w_shifted[15:0]};
            2'd2: w_load_ext = {{(XLEN-32){w_shifted[31] & ~r_f3[2]}}, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_ex_ready     <= 1'b1;
            r_dc_req_valid <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_dc_req_addr  <= '0;
            r_dc_req_we    <= 1'b0;
            r_dc_req_wdata <= '0;
            r_dc_req_be    <= '0;
            r_loaded       <= '0;
            r_alu          <= '0;
            r_ctrl         <= '0;
            r_mis          <= 1'b0;
            r_off          <= '0;
            r_f3           <= '0;
            r_is_load      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        r_ex_ready     <= 1'b0;
                        r_alu          <= ex_alu_data;
                        r_ctrl         <= w_ctrl_cap;
                        r_mis          <= w_mis;
                        r_loaded       <= '0;
                        r_off          <= w_off;
                        r_f3           <= w_f3;
                        r_is_load      <= ex_ctrl[6] & ~ex_ctrl[7];
                        r_dc_req_addr  <= {ex_alu_data[XLEN-1:3], 3'b000};
                        r_dc_req_we    <= w_store;
                        r_dc_req_wdata <= ex_store_data << {w_off, 3'b000};
                        r_dc_req_be    <= w_be_base << w_off;
                        if (w_mem && !w_mis) begin
                            r_state        <= S_REQ;
                            r_dc_req_valid <= 1'b1;
                        end else begin
                            r_state    <= S_OUT;
                            r_wb_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_dc_req_valid <= 1'b0;
                        // An accepted request still owes us a response.
                        if (dc_req_ready) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state    <= S_IDLE;
                            r_ex_ready <= 1'b1;
                        end
                    end else if (dc_req_ready) begin
                        r_dc_req_valid <= 1'b0;
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dc_resp_valid) begin
                        if (flush) begin
                            r_state    <= S_IDLE;
                            r_ex_ready <= 1'b1;
                        end else begin
                            r_loaded   <= r_is_load ? w_load_ext : '0;
                            r_state    <= S_OUT;
                            r_wb_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_OUT: begin
                    if (flush || wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                        r_ex_ready <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dc_resp_valid) begin
                        r_state    <= S_IDLE;
                        r_ex_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_ex_ready     <= 1'b1;
                    r_dc_req_valid <= 1'b0;
                    r_wb_valid     <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready        = r_ex_ready;
    assign dc_req_valid    = r_dc_req_valid;
    assign dc_req_addr     = r_dc_req_addr;
    assign dc_req_we       = r_dc_req_we;
    assign dc_req_wdata    = r_dc_req_wdata;
    assign dc_req_be       = r_dc_req_be;
    assign wb_valid        = r_wb_valid;
    assign loaded_data     = r_loaded;
    assign alu_data        = r_alu;
    assign control_signals = r_ctrl;
    assign misaligned      = r_mis;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed vector bench for memory_access_stage
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_alu_data;
    logic [63:0] ex_store_data;
    logic [63:0] ex_ctrl;
    logic        flush;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic [63:0] dc_req_addr;
    logic        dc_req_we;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_be;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] loaded_data;
    logic [63:0] alu_data;
    logic [63:0] control_signals;
    logic        misaligned;

    memory_access_stage #(.XLEN(64), .CTRL_W(64)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data), .ex_ctrl(ex_ctrl),
        .flush(flush),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .loaded_data(loaded_data), .alu_data(alu_data),
        .control_signals(control_signals), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] sd;
        logic [63:0] ctrl;
        logic [63:0] resp;
        logic [63:0] exp_ld;
        logic [63:0] exp_addr;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic        exp_we;
        logic        exp_mis;
        logic        exp_mem;
        logic [63:0] exp_ctrl;
    } vec_t;

    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = -1;

    function automatic logic [63:0] cw(input logic [4:0] rd, input logic rw, input logic mr,
                                       input logic mw, input logic [2:0] f3);
        return {53'd0, f3, mw, mr, rw, rd};
    endfunction

    function automatic vec_t mk(input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] ctrl,
                                input logic [63:0] resp, input logic [63:0] exp_ld,
                                input logic [63:0] exp_addr, input logic [7:0] exp_be,
                                input logic [63:0] exp_wdata, input logic exp_we, input logic exp_mis,
                                input logic exp_mem, input logic [63:0] exp_ctrl);
        vec_t v;
        v.alu = alu; v.sd = sd; v.ctrl = ctrl; v.resp = resp; v.exp_ld = exp_ld;
        v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_we = exp_we;
        v.exp_mis = exp_mis; v.exp_mem = exp_mem; v.exp_ctrl = exp_ctrl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (case %0d): got 0x%h expected 0x%h", nm, cur, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 64'(act), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] ctrl);
        ex_valid = 1'b1; ex_alu_data = alu; ex_store_data = sd; ex_ctrl = ctrl;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_ex_ready", ex_ready, 1'b1);
        chk1("rst_req_valid", dc_req_valid, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_we", dc_req_we, 1'b0);
        chk1("rst_mis", misaligned, 1'b0);
        chk("rst_addr", dc_req_addr, 64'd0);
        chk("rst_wdata", dc_req_wdata, 64'd0);
        chk("rst_be", 64'(dc_req_be), 64'd0);
        chk("rst_loaded", loaded_data, 64'd0);
        chk("rst_alu", alu_data, 64'd0);
        chk("rst_ctrl", control_signals, 64'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        cur = i;
        chk1("ex_ready_idle", ex_ready, 1'b1);
        issue(v.alu, v.sd, v.ctrl);
        chk1("ex_ready_busy", ex_ready, 1'b0);
        if (v.exp_mem) begin
            chk1("req_valid", dc_req_valid, 1'b1);
            chk1("wb_early", wb_valid, 1'b0);
            chk("req_addr", dc_req_addr, v.exp_addr);
            chk("req_be", 64'(dc_req_be), 64'(v.exp_be));
            chk("req_wdata", dc_req_wdata, v.exp_wdata);
            chk1("req_we", dc_req_we, v.exp_we);
            dc_req_ready = 1'b1;
            tick();
            dc_req_ready = 1'b0;
            chk1("req_dropped", dc_req_valid, 1'b0);
            dc_resp_valid = 1'b1; dc_resp_data = v.resp;
            tick();
            dc_resp_valid = 1'b0; dc_resp_data = 64'd0;
        end else begin
            chk1("no_req", dc_req_valid, 1'b0);
        end
        chk1("wb_valid", wb_valid, 1'b1);
        chk("loaded", loaded_data, v.exp_ld);
        chk("alu_data", alu_data, v.alu);
        chk("ctrl", control_signals, v.exp_ctrl);
        chk1("misaligned", misaligned, v.exp_mis);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk1("wb_done", wb_valid, 1'b0);
        chk1("ex_ready_back", ex_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; ex_alu_data = '0; ex_store_data = '0; ex_ctrl = '0;
        flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0; wb_ready = 1'b0;

        vecs[0]  = mk(64'h1234, 64'd0, cw(5, 1, 0, 0, 3'd0), 64'd0, 64'd0,
                      64'd0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b0, cw(5, 1, 0, 0, 3'd0));
        vecs[1]  = mk(64'h1003, 64'd0, cw(7, 1, 1, 0, 3'd0), 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80,
                      64'h1000, 8'h08, 64'd0, 1'b0, 1'b0, 1'b1, cw(7, 1, 1, 0, 3'd0));
        vecs[2]  = mk(64'h1003, 64'd0, cw(7, 1, 1, 0, 3'd4), 64'h0000_0000_8000_0000, 64'h80,
                      64'h1000, 8'h08, 64'd0, 1'b0, 1'b0, 1'b1, cw(7, 1, 1, 0, 3'd4));
        vecs[3]  = mk(64'h2006, 64'hBEEF, cw(0, 1, 0, 1, 3'd1), 64'hDEAD, 64'd0,
                      64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b1, 1'b0, 1'b1, cw(0, 0, 0, 1, 3'd1));
        vecs[4]  = mk(64'h3002, 64'd0, cw(9, 1, 1, 0, 3'd2), 64'd0, 64'd0,
                      64'd0, 8'h00, 64'd0, 1'b0, 1'b1, 1'b0, cw(9, 0, 1, 0, 3'd2));
        vecs[5]  = mk(64'h4008, 64'd0, cw(10, 1, 1, 0, 3'd3), 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                      64'h4008, 8'hFF, 64'd0, 1'b0, 1'b0, 1'b1, cw(10, 1, 1, 0, 3'd3));
        vecs[6]  = mk(64'h5002, 64'd0, cw(11, 1, 1, 0, 3'd1), 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765,
                      64'h5000, 8'h0C, 64'd0, 1'b0, 1'b0, 1'b1, cw(11, 1, 1, 0, 3'd1));
        vecs[7]  = mk(64'h6004, 64'd0, cw(12, 1, 1, 0, 3'd6), 64'h9ABC_DEF0_0000_0000, 64'h0000_0000_9ABC_DEF0,
                      64'h6000, 8'hF0, 64'd0, 1'b0, 1'b0, 1'b1, cw(12, 1, 1, 0, 3'd6));
        vecs[8]  = mk(64'h6004, 64'd0, cw(12, 1, 1, 0, 3'd2), 64'h9ABC_DEF0_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0,
                      64'h6000, 8'hF0, 64'd0, 1'b0, 1'b0, 1'b1, cw(12, 1, 1, 0, 3'd2));
        vecs[9]  = mk(64'h7005, 64'hFFFF_FFFF_FFFF_FF55, cw(0, 0, 1, 1, 3'd0), 64'h1234, 64'd0,
                      64'h7000, 8'h20, 64'hFFFF_5500_0000_0000, 1'b1, 1'b0, 1'b1, cw(0, 0, 1, 1, 3'd0));
        vecs[10] = mk(64'h8004, 64'h1111, cw(0, 0, 0, 1, 3'd3), 64'd0, 64'd0,
                      64'd0, 8'h00, 64'd0, 1'b0, 1'b1, 1'b0, cw(0, 0, 0, 1, 3'd3));

        repeat (2) tick();
        chk_reset_outputs();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_vec(i);

        // LD stalled three cycles at the cache, then flushed in WAIT.
        cur = 100;
        issue(64'h9000, 64'd0, cw(3, 1, 1, 0, 3'd3));
        for (int k = 0; k < 3; k++) begin
            chk1("stall_req_valid", dc_req_valid, 1'b1);
            chk("stall_req_addr", dc_req_addr, 64'h9000);
            tick();
        end
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("drain_wb", wb_valid, 1'b0);
        chk1("drain_ex_ready", ex_ready, 1'b0);
        tick();
        chk1("drain_hold_ex_ready", ex_ready, 1'b0);
        dc_resp_valid = 1'b1; dc_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dc_resp_valid = 1'b0; dc_resp_data = 64'd0;
        chk1("drain_done_ex_ready", ex_ready, 1'b1);
        chk1("drain_done_wb", wb_valid, 1'b0);
        tick();
        chk1("drain_after_wb", wb_valid, 1'b0);

        // Write-back back-pressure holds the bundle.
        cur = 101;
        issue(64'hCAFE, 64'd0, cw(1, 1, 0, 0, 3'd0));
        for (int k = 0; k < 4; k++) begin
            chk1("bp_wb_valid", wb_valid, 1'b1);
            chk("bp_alu", alu_data, 64'hCAFE);
            chk("bp_ctrl", control_signals, cw(1, 1, 0, 0, 3'd0));
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk1("bp_released", wb_valid, 1'b0);

        // Flush while the bundle is presented.
        cur = 102;
        issue(64'h77, 64'd0, cw(2, 1, 0, 0, 3'd0));
        chk1("fo_wb_valid", wb_valid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("fo_wb_dropped", wb_valid, 1'b0);
        chk1("fo_ex_ready", ex_ready, 1'b1);

        // Flush in REQ before the cache accepts.
        cur = 103;
        issue(64'hA000, 64'd0, cw(4, 1, 1, 0, 3'd3));
        chk1("fr_req_valid", dc_req_valid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("fr_req_dropped", dc_req_valid, 1'b0);
        chk1("fr_ex_ready", ex_ready, 1'b1);
        chk1("fr_wb_valid", wb_valid, 1'b0);

        // Asynchronous reset mid-WAIT.
        cur = 104;
        issue(64'h1003, 64'd0, cw(7, 1, 1, 0, 3'd0));
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        chk1("rw_in_wait", ex_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        #1;
        reset = 1'b1;
        tick();
        chk1("rw_after_ex_ready", ex_ready, 1'b1);
        chk1("rw_after_wb", wb_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
